// File: rtl/mv_collector.sv
// mv_collector: FIFO of per-block {blk_idx, mv_y, mv_x, sad} results with frame indexing and sticky overflow.
// Define MV_COLLECT_STATS_EN to add the per-frame SAD total output frame_sad_sum.
module mv_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int BLK_PER_FRAME = 16,
  parameter int BLK_IDX_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sad_en,
  input  logic [13:0]           sad_min,
  input  logic [3:0]            motion_vec_x_min,
  input  logic [3:0]            motion_vec_y_min,
  input  logic                  res_ready,
  input  logic                  ovf_clr,
  output logic                  res_valid,
  output logic [BLK_IDX_W+21:0] res_data,
  output logic [4:0]            fifo_cnt,
  output logic                  frame_done,
`ifdef MV_COLLECT_STATS_EN
  output logic [25:0]           frame_sad_sum,
`endif
  output logic                  ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
  localparam logic [BLK_IDX_W-1:0] LAST = BLK_IDX_W'(BLK_PER_FRAME - 1);
  logic [BLK_IDX_W+21:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [BLK_IDX_W-1:0] blk_idx;
  logic pop, push, drop, last;
  // A full buffer still accepts a result when the head leaves on the same edge
  always_comb begin
    pop  = res_valid && res_ready;
    push = sad_en && (fifo_cnt < DEPTH || pop);
    drop = sad_en && !push;
    last = blk_idx == LAST;
  end
  assign res_valid = fifo_cnt != 5'd0;
  assign res_data  = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push && rst_n) mem[wr_ptr] <= {blk_idx, motion_vec_y_min, motion_vec_x_min, sad_min};
  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      blk_idx    <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + 5'(push) - 5'(pop);
      if (sad_en) blk_idx <= last ? '0 : blk_idx + 1'b1;
      frame_done <= sad_en && last;
      ovf <= drop || (ovf && !ovf_clr);
    end
`ifdef MV_COLLECT_STATS_EN
  logic [25:0] acc, acc_sum;
  assign acc_sum = acc + 26'(sad_min);
  always_ff @(posedge clk)
    if (!rst_n) begin
      acc           <= '0;
      frame_sad_sum <= '0;
    end else if (sad_en) begin
      acc <= last ? '0 : acc_sum;
      if (last) frame_sad_sum <= acc_sum;
    end
`endif
endmodule
